comparator_4b_cascade: RTL and testbench
========================================

Name: comparator_4b_cascade

Overview:
- Cascadable 4-bit magnitude comparator with registered outputs, in the style of a 74x85 slice.
- Compares unsigned a against b. When the operands are equal, the result is taken from the cascade inputs of a less-significant slice.
- Used standalone (cascade inputs tied l=0, g=1, m=0) or chained to form wider comparators.

Parameters:
- WIDTH, 4, operand width in bits. Fixed at 4 for this block; other values are not supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- in_l  input  1  cascade input "less" from the less-significant slice
- in_g  input  1  cascade input "equal" from the less-significant slice (g = equal/"gleich")
- in_m  input  1  cascade input "more" from the less-significant slice
- l  output  1  registered result: A < B
- g  output  1  registered result: A == B
- m  output  1  registered result: A > B

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low clears l, g and m to 0 immediately, independent of clk.
  - Outputs hold 0 until the first rising clk edge after rst_n deasserts.
- Comparison (combinational next-state; a and b are unsigned 0..15):
  - a < b: next {l,g,m} = {1,0,0}.
  - a > b: next {l,g,m} = {0,0,1}.
  - a == b: next l = in_l, g = in_g, m = in_m (transparent pass-through, no checking).
- Cascade inputs affect the result only when a == b.
- Latency: exactly one clock.
  - Outputs update on every rising clk edge, from a, b, in_* sampled at that edge.
  - There is no enable and no handshake; a new result is produced every cycle.
- One-hot property:
  - If the cascade inputs are one-hot, the outputs are one-hot after the first post-reset edge.
  - If the cascade inputs are not one-hot, a == b passes that pattern through unchanged (including 000 or 111).
- Boundaries:
  - a=0, b=15: l=1.
  - a=15, b=0: m=1.
  - a=b=0 and a=b=15 behave as equal.
  - No wrap-around or overflow is possible.
- Reset mid-operation: asserting rst_n forces 000 asynchronously. The pipeline register holds no other state.
- Cascading: connect l/g/m of the lower slice to in_l/in_g/in_m of the upper slice. Each slice adds one cycle of latency, so the user balances pipeline depth.

Test Plan:
- Reset check: hold rst_n=0 with a=3, b=5 and toggle clk -> l=g=m=0. Release rst_n, then one edge -> l=1, g=0, m=0.
- Exhaustive sweep with cascade tied in_l=0, in_g=1, in_m=0: all 256 (a,b) pairs, one per clock. Each result is checked one cycle later:
  - l = (a<b), g = (a==b), m = (a>b).
  - The outputs are one-hot for every pair.
- Cascade pass-through with a=b=9:
  - in={1,0,0} -> {l,g,m}={1,0,0}
  - in={0,0,1} -> {0,0,1}
  - in={0,0,0} -> {0,0,0}
- Cascade ignored when unequal: a=12, b=4 with in_l=1, in_g=0, in_m=0 -> {0,0,1}. Then a=4, b=12 with in_m=1 -> {1,0,0}.
- Latency: change a from 2 to 7 with b=5 just after an edge -> l stays 1 until the next edge, then m=1 and l=0.
- Asynchronous reset mid-stream: assert rst_n between edges while m=1 -> m drops to 0 without a clock edge. Results resume one edge after release.

Source files
------------

// File: rtl/comparator_4b_cascade_if.sv
// Operand, cascade and result signals of one comparator slice.
// The master drives the operands and cascade inputs and reads the results.
// The slave is the comparator itself.
interface comparator_4b_cascade_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_l;
  logic             in_g;
  logic             in_m;
  logic             l;
  logic             g;
  logic             m;

  modport master (
    output a, b, in_l, in_g, in_m,
    input  l, g, m
  );

  modport slave (
    input  a, b, in_l, in_g, in_m,
    output l, g, m
  );
endinterface

// File: rtl/comparator_4b_cascade.sv
// Cascadable 4-bit unsigned magnitude comparator, in the style of a 74x85 slice.
// The outputs are registered, so the block has one clock of latency.
// When a == b, the result comes from the cascade inputs of the less-significant slice.
module comparator_4b_cascade #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  comparator_4b_cascade_if.slave cmp
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_next_lgm;
  logic [2:0]       r_lgm;

  assign w_a = cmp.a;
  assign w_b = cmp.b;

  // Next result {l,g,m}. The magnitude decides the result unless the operands are equal.
  always_comb begin
    w_next_lgm = 3'b000;
    if (w_a < w_b) begin
      w_next_lgm = 3'b100;
    end else if (w_a > w_b) begin
      w_next_lgm = 3'b001;
    end else begin
      // On equal operands, pass the cascade pattern through unchanged.
      // Patterns that are not one-hot (for example 000 or 111) pass through as well.
      w_next_lgm = {cmp.in_l, cmp.in_g, cmp.in_m};
    end
  end

  // Result register. Asynchronous reset clears it to 000.
  // After reset it loads the new result on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lgm <= 3'b000;
    end else begin
      r_lgm <= w_next_lgm;
    end
  end

  assign cmp.l = r_lgm[2];
  assign cmp.g = r_lgm[1];
  assign cmp.m = r_lgm[0];

endmodule

// File: tb/tb_comparator_4b_cascade.sv
// Scoreboard testbench for comparator_4b_cascade.
// A driver pushes expected results from a reference model into a queue.
// A monitor pops one result per clock and compares it with the outputs.
// Directed checks cover reset, latency and an asynchronous reset mid-stream.
module tb_comparator_4b_cascade;

  typedef struct {
    logic [2:0] lgm;
    bit         onehot;
    int         a;
    int         b;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   sb_on;
  exp_t sb_q[$];

  comparator_4b_cascade_if #(.WIDTH(4)) cif();

  comparator_4b_cascade #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: compare the signed integer difference of a and b.
  // On a tie, return the cascade pattern.
  function automatic logic [2:0] ref_model(int a, int b, logic [2:0] casc);
    int d;
    d = a - b;
    if (d < 0) return 3'b100;
    if (d > 0) return 3'b001;
    return casc;
  endfunction

  task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got lgm=%b, expected lgm=%b", name, act, exp);
    end
  endtask

  // Apply one input vector between clock edges.
  // Queue the result expected after the next rising edge.
  task automatic drive(int a, int b, logic [2:0] casc);
    exp_t e;
    @(negedge clk);
    cif.a    = a[3:0];
    cif.b    = b[3:0];
    cif.in_l = casc[2];
    cif.in_g = casc[1];
    cif.in_m = casc[0];
    e.lgm    = ref_model(a, b, casc);
    e.onehot = ($countones(casc) == 1);
    e.a      = a;
    e.b      = b;
    sb_q.push_back(e);
  endtask

  // Monitor: a result appears every rising edge.
  // Pop the expected result and compare it just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_on && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check3($sformatf("result a=%0d b=%0d", e.a, e.b), {cif.l, cif.g, cif.m}, e.lgm);
        if (e.onehot) begin
          n_cmp++;
          if ($countones({cif.l, cif.g, cif.m}) != 1) begin
            n_err++;
            $display("FAIL onehot a=%0d b=%0d: got lgm=%b, expected exactly one bit set",
                     e.a, e.b, {cif.l, cif.g, cif.m});
          end
        end
      end
    end
  end

  // Watchdog: stop the run if it exceeds its time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    sb_on = 1'b0;
    rst_n = 1'b0;
    cif.a = 4'd3;
    cif.b = 4'd5;
    cif.in_l = 1'b0;
    cif.in_g = 1'b1;
    cif.in_m = 1'b0;

    // Reset held low while the clock toggles.
    repeat (3) @(posedge clk);
    #1;
    check3("reset_hold", {cif.l, cif.g, cif.m}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check3("reset_release_no_edge", {cif.l, cif.g, cif.m}, 3'b000);
    @(posedge clk);
    #1;
    check3("first_edge_3_lt_5", {cif.l, cif.g, cif.m}, 3'b100);

    // Exhaustive sweep with the cascade tied for standalone use.
    sb_on = 1'b1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        drive(ia, ib, 3'b010);
      end
    end

    // Cascade pass-through on equal operands.
    drive(9, 9, 3'b100);
    drive(9, 9, 3'b001);
    drive(9, 9, 3'b000);
    drive(9, 9, 3'b111);
    // The cascade inputs are ignored when the operands differ.
    drive(12, 4, 3'b100);
    drive(4, 12, 3'b001);

    // Random operands and cascade patterns; about one vector in four has equal operands.
    for (int i = 0; i < 300; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(15, 0));
      rb = ($urandom_range(3, 0) == 0) ? ra : int'($urandom_range(15, 0));
      drive(ra, rb, 3'($urandom_range(7, 0)));
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
    end
    sb_on = 1'b0;

    // Latency: the output changes only at the next rising edge.
    @(negedge clk);
    cif.a = 4'd2;
    cif.b = 4'd5;
    @(posedge clk);
    #1;
    check3("latency_before", {cif.l, cif.g, cif.m}, 3'b100);
    #1;
    cif.a = 4'd7;
    #2;
    check3("latency_hold", {cif.l, cif.g, cif.m}, 3'b100);
    @(posedge clk);
    #1;
    check3("latency_after", {cif.l, cif.g, cif.m}, 3'b001);

    // Asynchronous reset between edges while m is 1.
    #2;
    rst_n = 1'b0;
    #1;
    check3("async_reset_mid", {cif.l, cif.g, cif.m}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check3("async_release_no_edge", {cif.l, cif.g, cif.m}, 3'b000);
    @(posedge clk);
    #1;
    check3("resume_after_reset", {cif.l, cif.g, cif.m}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
